// File: rtl/xgmii_rx_fault_monitor.sv
// XGMII receive link-fault monitor: detects LF/RF sequence ordered sets and drives link status bits.
// Define XGMII_RX_FAULT_MON_STATS_EN to build the frame/error statistics counters.
module xgmii_rx_fault_monitor #(
    parameter int FAULT_THRESH = 4,
    parameter int WINDOW       = 64,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 clear_counters,
    output logic                 local_fault,
    output logic                 remote_fault,
    output logic                 link_ok,
    output logic                 send_remote_fault,
    output logic [CNT_WIDTH-1:0] rx_frame_count,
    output logic [CNT_WIDTH-1:0] rx_error_count
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_FAULT} state_t;
    typedef enum logic [1:0] {T_NONE, T_LF, T_RF} ftype_t;

    localparam int             WW       = $clog2(WINDOW + 1);
    localparam logic [WW-1:0]  WIN_LAST = WW'(WINDOW - 1);
    localparam logic [3:0]     THRESH   = 4'(FAULT_THRESH);

    state_t        state, state_nx;
    ftype_t        last_type, last_nx;
    logic [3:0]    seq_cnt, seq_nx;
    logic [WW-1:0] win_cnt, win_nx;

    ftype_t     col0, col1, word_t;
    logic [1:0] word_n;
    logic [4:0] seq_sum;
    logic [3:0] seq_sat;

    function automatic ftype_t col_type(input logic [31:0] d, input logic [3:0] c);
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01) return T_LF;
            if (d[31:24] == 8'h02) return T_RF;
        end
        return T_NONE;
    endfunction

    // Mixed-type words count only column 1, so the later column wins the type.
    always_comb begin
        col0   = col_type(xgmii_rxd[31:0],  xgmii_rxc[3:0]);
        col1   = col_type(xgmii_rxd[63:32], xgmii_rxc[7:4]);
        word_n = 2'd0;
        word_t = T_NONE;
        if (col1 != T_NONE) begin
            word_t = col1;
            word_n = (col0 == col1) ? 2'd2 : 2'd1;
        end else if (col0 != T_NONE) begin
            word_t = col0;
            word_n = 2'd1;
        end
        seq_sum = {1'b0, seq_cnt} + {3'b000, word_n};
        seq_sat = seq_sum[4] ? 4'hF : seq_sum[3:0];
    end

    always_comb begin
        state_nx = state;
        last_nx  = last_type;
        seq_nx   = seq_cnt;
        win_nx   = win_cnt;
        case (state)
            S_IDLE: begin
                if (word_n != 2'd0) begin
                    state_nx = S_COUNT;
                    last_nx  = word_t;
                    seq_nx   = {2'b00, word_n};
                    win_nx   = '0;
                end
            end
            S_COUNT, S_FAULT: begin
                if (word_n != 2'd0 && word_t == last_type) begin
                    win_nx = '0;
                    if (state == S_COUNT) begin
                        seq_nx = seq_sat;
                        if (seq_sat >= THRESH) state_nx = S_FAULT;
                    end
                end else if (word_n != 2'd0) begin
                    state_nx = S_COUNT;
                    last_nx  = word_t;
                    seq_nx   = {2'b00, word_n};
                    win_nx   = '0;
                end else if (win_cnt == WIN_LAST) begin
                    state_nx = S_IDLE;
                    last_nx  = T_NONE;
                    seq_nx   = '0;
                    win_nx   = '0;
                end else begin
                    win_nx = win_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                last_nx  = T_NONE;
                seq_nx   = '0;
                win_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            last_type         <= T_NONE;
            seq_cnt           <= '0;
            win_cnt           <= '0;
            local_fault       <= 1'b0;
            remote_fault      <= 1'b0;
            link_ok           <= 1'b1;
            send_remote_fault <= 1'b0;
        end else begin
            state             <= state_nx;
            last_type         <= last_nx;
            seq_cnt           <= seq_nx;
            win_cnt           <= win_nx;
            local_fault       <= (state_nx == S_FAULT) && (last_nx == T_LF);
            remote_fault      <= (state_nx == S_FAULT) && (last_nx == T_RF);
            link_ok           <= !(state_nx == S_FAULT && (last_nx == T_LF || last_nx == T_RF));
            send_remote_fault <= (state_nx == S_FAULT) && (last_nx == T_LF);
        end
    end

`ifdef XGMII_RX_FAULT_MON_STATS_EN
    logic [1:0]           sof_inc;
    logic [3:0]           err_inc;
    logic [CNT_WIDTH:0]   fc_sum, ec_sum;

    always_comb begin
        sof_inc = 2'd0;
        err_inc = 4'd0;
        if (xgmii_rxc[0] && xgmii_rxd[7:0] == 8'hFB)   sof_inc = sof_inc + 2'd1;
        if (xgmii_rxc[4] && xgmii_rxd[39:32] == 8'hFB) sof_inc = sof_inc + 2'd1;
        for (int k = 0; k < 8; k++) begin
            if (xgmii_rxc[k] && xgmii_rxd[8*k +: 8] == 8'hFE) err_inc = err_inc + 4'd1;
        end
        fc_sum = {1'b0, rx_frame_count} + (CNT_WIDTH+1)'(sof_inc);
        ec_sum = {1'b0, rx_error_count} + (CNT_WIDTH+1)'(err_inc);
    end

    // Carry out of the widened sum means the counter would wrap: pin at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clear_counters) begin
            rx_frame_count <= '0;
            rx_error_count <= '0;
        end else begin
            rx_frame_count <= fc_sum[CNT_WIDTH] ? '1 : fc_sum[CNT_WIDTH-1:0];
            rx_error_count <= ec_sum[CNT_WIDTH] ? '1 : ec_sum[CNT_WIDTH-1:0];
        end
    end
`else
    logic unused_clear;
    assign unused_clear   = clear_counters;
    assign rx_frame_count = '0;
    assign rx_error_count = '0;
`endif

endmodule

// File: tb/tb_xgmii_rx_fault_monitor.sv
// Scoreboard bench for xgmii_rx_fault_monitor: event-level reference model, directed and random words.
module tb_xgmii_rx_fault_monitor;

    localparam int THRESH = 4;
    localparam int WIN    = 64;
    localparam int CW     = 8;
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam longint CMAX = (64'd1 << CW) - 1;

`ifdef XGMII_RX_FAULT_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_counters = 1'b0;
    logic [63:0]   xgmii_rxd = IDLE_D;
    logic [7:0]    xgmii_rxc = 8'hFF;
    logic          local_fault, remote_fault, link_ok, send_remote_fault;
    logic [CW-1:0] rx_frame_count, rx_error_count;

    xgmii_rx_fault_monitor #(.FAULT_THRESH(THRESH), .WINDOW(WIN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .clear_counters(clear_counters), .local_fault(local_fault), .remote_fault(remote_fault),
        .link_ok(link_ok), .send_remote_fault(send_remote_fault),
        .rx_frame_count(rx_frame_count), .rx_error_count(rx_error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic lf, rf, ok, srf;
        logic [CW-1:0] fc, ec;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: type of the current run, fault columns in the run, quiet words since last fault word.
    int     m_type = 0;
    int     m_run = 0;
    int     m_quiet = 0;
    bit     m_faulted = 0;
    longint m_fc = 0;
    longint m_ec = 0;

    function automatic int col_kind(input logic [31:0] d, input logic [3:0] c);
        if (c != 4'b0001 || d[23:0] != 24'h00009C) return 0;
        if (d[31:24] == 8'h01) return 1;
        if (d[31:24] == 8'h02) return 2;
        return 0;
    endfunction

    task automatic model_step(input logic [63:0] d, input logic [7:0] c, input bit clr, input bit r);
        int k0, k1, n, t, sof, err;
        exp_t e;
        if (r) begin
            m_type = 0; m_run = 0; m_quiet = 0; m_faulted = 0; m_fc = 0; m_ec = 0;
        end else begin
            k0 = col_kind(d[31:0], c[3:0]);
            k1 = col_kind(d[63:32], c[7:4]);
            n  = int'(k0 != 0) + int'(k1 != 0);
            t  = (k1 != 0) ? k1 : k0;
            if (k0 != 0 && k1 != 0 && k0 != k1) n = 1;
            if (n > 0) begin
                m_quiet = 0;
                if (t != m_type) begin
                    m_type = t; m_run = n; m_faulted = 0;
                end else begin
                    m_run = (m_run + n > 15) ? 15 : m_run + n;
                    if (m_run >= THRESH) m_faulted = 1;
                end
            end else begin
                m_quiet++;
                if (m_quiet >= WIN) begin
                    m_type = 0; m_run = 0; m_faulted = 0; m_quiet = 0;
                end
            end
            sof = 0;
            err = 0;
            for (int l = 0; l < 8; l++) if (c[l] && d[8*l +: 8] == 8'hFE) err++;
            if (c[0] && d[7:0] == 8'hFB) sof++;
            if (c[4] && d[39:32] == 8'hFB) sof++;
            if (clr || !STATS) begin
                m_fc = 0; m_ec = 0;
            end else begin
                m_fc = (m_fc + sof > CMAX) ? CMAX : m_fc + sof;
                m_ec = (m_ec + err > CMAX) ? CMAX : m_ec + err;
            end
        end
        e.lf  = m_faulted && m_type == 1;
        e.rf  = m_faulted && m_type == 2;
        e.ok  = !m_faulted;
        e.srf = m_faulted && m_type == 1;
        e.fc  = CW'(m_fc);
        e.ec  = CW'(m_ec);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c, input bit clr = 1'b0, input bit r = 1'b0);
        @(negedge clk);
        xgmii_rxd = d; xgmii_rxc = c; clear_counters = clr; rst = r;
        model_step(d, c, clr, r);
    endtask

    task automatic idles(input int k);
        for (int i = 0; i < k; i++) drive(IDLE_D, 8'hFF);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("local_fault", 32'(local_fault), 32'(e.lf));
                chk("remote_fault", 32'(remote_fault), 32'(e.rf));
                chk("link_ok", 32'(link_ok), 32'(e.ok));
                chk("send_remote_fault", 32'(send_remote_fault), 32'(e.srf));
                chk("rx_frame_count", 32'(rx_frame_count), 32'(e.fc));
                chk("rx_error_count", 32'(rx_error_count), 32'(e.ec));
            end
        end
    end

    function automatic logic [35:0] rand_col(input bit allow_fault);
        int sel;
        sel = allow_fault ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 7));
        case (sel)
            0, 1, 2: return {4'hF, 32'h07070707};
            3:       return {4'b0001, 24'($urandom), 8'hFB};
            4:       return {4'($urandom), 32'hFEFEFEFE};
            5:       return {4'b0011, 32'h0100009C};
            6:       return {4'b0001, 8'($urandom_range(3, 255)), 24'h00009C};
            7:       return {4'h0, 32'($urandom)};
            8, 9:    return {4'b0001, 32'h0100009C};
            default: return {4'b0001, 32'h0200009C};
        endcase
    endfunction

    localparam logic [31:0] LF_COL = 32'h0100009C;
    localparam logic [31:0] RF_COL = 32'h0200009C;

    initial begin : stim
        logic [35:0] a, b;
        logic [31:0] fc_col;
        int len;
        drive(IDLE_D, 8'hFF, 1'b0, 1'b1);
        drive(IDLE_D, 8'hFF, 1'b0, 1'b1);
        idles(200);
        // LF assert then window expiry
        repeat (4) drive({32'h07070707, LF_COL}, 8'hF1);
        idles(63);
        idles(2);
        // RF in both columns, mixed word, then LF-only
        repeat (2) drive({RF_COL, RF_COL}, 8'h11);
        drive({RF_COL, LF_COL}, 8'h11);
        drive({32'h07070707, LF_COL}, 8'hF1);
        idles(70);
        // alternating types never reach threshold
        for (int i = 0; i < 4; i++) drive({32'h07070707, (i % 2 == 0) ? LF_COL : RF_COL}, 8'hF1);
        idles(66);
        // statistics
        repeat (10) drive(64'hFEFEFE07_070707FB, 8'hE1);
        drive(64'hFEFEFE07_070707FB, 8'hE1, 1'b1);
        idles(2);
        repeat (140) drive(64'hFEFEFEFB_FEFEFEFB, 8'hFF);
        drive(64'hFEFEFEFB_FEFEFEFB, 8'hFF, 1'b1);
        // reset mid-fault
        repeat (4) drive({32'h07070707, LF_COL}, 8'hF1);
        idles(3);
        drive(IDLE_D, 8'hFF, 1'b0, 1'b1);
        idles(3);
        // bursts of one fault type followed by quiet runs around the window length
        for (int bst = 0; bst < 60; bst++) begin
            fc_col = ($urandom_range(0, 1) == 0) ? LF_COL : RF_COL;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0: drive({32'h07070707, fc_col}, 8'hF1);
                    1: drive({fc_col, 32'h07070707}, 8'h1F);
                    2: drive({fc_col, fc_col}, 8'h11);
                    default: drive({fc_col, (fc_col == LF_COL) ? RF_COL : LF_COL}, 8'h11);
                endcase
            end
            len = int'($urandom_range(0, 80));
            for (int i = 0; i < len; i++) begin
                a = rand_col(1'b0);
                b = rand_col(1'b0);
                drive({b[31:0], a[31:0]}, {b[35:32], a[35:32]}, ($urandom_range(0, 49) == 0));
            end
        end
        // fully random words
        for (int i = 0; i < 2000; i++) begin
            a = rand_col(1'b1);
            b = rand_col(1'b1);
            drive({b[31:0], a[31:0]}, {b[35:32], a[35:32]},
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
        end
        idles(2);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
